// File: rtl/fp_addsub_sequencer.sv
// Request FIFO plus issue/wait/hold sequencer in front of an FP32 addsub responder.
// Operands and results pass through bit-exact; one request is outstanding at a time.
module fp_addsub_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_mode,
    input  logic [31:0]              req_op1,
    input  logic [31:0]              req_op2,
    output logic                     add_start,
    output logic                     mode,
    output logic [31:0]              op1,
    output logic [31:0]              op2,
    input  logic                     add_done,
    input  logic [31:0]              add_result,
    input  logic                     add_overflow,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_result,
    output logic                     rsp_overflow,
    output logic                     rsp_timeout,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    typedef struct packed {
        logic        mode;
        logic [31:0] op1;
        logic [31:0] op2;
    } req_t;

    state_t          state;
    req_t            mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [TW-1:0]   timer;
    logic            push;
    logic            pop;

    assign req_ready = (count != FULL_COUNT);
    assign push      = req_valid && req_ready;
    assign pop       = (state == IDLE) && (count != '0) && !rsp_valid;
    assign busy      = (state != IDLE) || (count != '0);

    // NOTE: the storage array has no reset; reset empties the FIFO through the pointers
    // and count, so stale entries are never read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= req_t'{mode: req_mode, op1: req_op1, op2: req_op2};
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every flop updates
    // from pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= IDLE;
            add_start    <= 1'b0;
            mode         <= 1'b0;
            op1          <= '0;
            op2          <= '0;
            timer        <= '0;
            rsp_valid    <= 1'b0;
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
            rsp_timeout  <= 1'b0;
        end else begin
            add_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        {mode, op1, op2} <= mem[rd_ptr];
                        add_start        <= 1'b1;
                        state            <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // A done pulse in the final timeout cycle still delivers its result.
                    if (add_done) begin
                        rsp_result   <= add_result;
                        rsp_overflow <= add_overflow;
                        rsp_timeout  <= 1'b0;
                        rsp_valid    <= 1'b1;
                        state        <= HOLD;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        rsp_result   <= '0;
                        rsp_overflow <= 1'b0;
                        rsp_timeout  <= 1'b1;
                        rsp_valid    <= 1'b1;
                        state        <= HOLD;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_addsub_sequencer.sv
// Bench for fp_addsub_sequencer: behavioural addsub responder with programmable latency,
// request-order scoreboard of expected responses, directed plus random stimulus.
module tb_fp_addsub_sequencer;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;

    typedef struct packed {
        logic [31:0] res;
        logic        ov;
        logic        to;
    } exp_t;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_mode;
    logic [31:0] req_op1;
    logic [31:0] req_op2;
    logic        add_start;
    logic        mode;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        add_done;
    logic [31:0] add_result;
    logic        add_overflow;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_overflow;
    logic        rsp_timeout;
    logic        busy;
    logic [$clog2(DEPTH):0] count;

    always #5 clk = ~clk;

    fp_addsub_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_mode     (req_mode),
        .req_op1      (req_op1),
        .req_op2      (req_op2),
        .add_start    (add_start),
        .mode         (mode),
        .op1          (op1),
        .op2          (op2),
        .add_done     (add_done),
        .add_result   (add_result),
        .add_overflow (add_overflow),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_overflow (rsp_overflow),
        .rsp_timeout  (rsp_timeout),
        .busy         (busy),
        .count        (count)
    );

    int   n_checks  = 0;
    int   n_pass    = 0;
    int   n_fail    = 0;
    int   n_pushed  = 0;
    int   start_cnt = 0;
    bit   dbl_start = 1'b0;
    bit   prev_start = 1'b0;
    bit   resp_on;
    int   resp_lat;
    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Normal-range single -> double conversion for the reference arithmetic.
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:0] == 31'd0) return 0.0;
        d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic void fp_model(input logic m, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] r, output logic ov);
        real         x;
        logic [63:0] d;
        int          e;
        x  = m ? (f2r(a) - f2r(b)) : (f2r(a) + f2r(b));
        d  = $realtobits(x);
        ov = 1'b0;
        if (d[62:0] == 63'd0) begin
            r = 32'd0;
        end else begin
            e = int'(d[62:52]) - 896;
            if (e >= 255) begin
                r  = {d[63], 8'hFF, 23'd0};
                ov = 1'b1;
            end else begin
                r = {d[63], e[7:0], d[51:29]};
            end
        end
    endfunction

    function automatic logic [31:0] rand_fp();
        return {1'($urandom), 8'($urandom_range(150, 100)), 23'($urandom)};
    endfunction

    // Behavioural addsub: captures operands on add_start, answers after the latency.
    initial begin
        logic        m;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        ov;
        int          lat;
        add_done     = 1'b0;
        add_result   = 32'd0;
        add_overflow = 1'b0;
        forever begin
            @(negedge clk);
            if (add_start === 1'b1 && resp_on) begin
                m   = mode;
                a   = op1;
                b   = op2;
                lat = (resp_lat == 0) ? int'($urandom_range(10, 1)) : resp_lat;
                repeat (lat) @(negedge clk);
                fp_model(m, a, b, r, ov);
                add_done     = 1'b1;
                add_result   = r;
                add_overflow = ov;
                @(negedge clk);
                add_done     = 1'b0;
                add_result   = $urandom;
                add_overflow = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (add_start === 1'b1) begin
            start_cnt++;
            if (prev_start) dbl_start = 1'b1;
        end
        prev_start = (add_start === 1'b1);
    end

    task automatic push_req(input logic m, input logic [31:0] a, input logic [31:0] b, input exp_t e);
        int waited;
        waited = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_mode  = m;
        req_op1   = a;
        req_op2   = b;
        while (req_ready !== 1'b1 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (req_ready !== 1'b1) begin
            check("push_accept", req_ready, 1'b1);
            req_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 req_valid = 1'b0;
            sb.push_back(e);
            n_pushed++;
        end
    endtask

    task automatic push_rand(input bit expect_timeout);
        logic        m;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        ov;
        m = 1'($urandom);
        a = rand_fp();
        b = rand_fp();
        fp_model(m, a, b, r, ov);
        if (expect_timeout) push_req(m, a, b, '{32'd0, 1'b0, 1'b1});
        else                push_req(m, a, b, '{r, ov, 1'b0});
    endtask

    task automatic collect(input int n);
        int   waited;
        exp_t e;
        for (int i = 0; i < n; i++) begin
            waited = 0;
            do begin
                @(negedge clk);
                waited++;
            end while (rsp_valid !== 1'b1 && waited < 300);
            check("rsp_arrived", rsp_valid, 1'b1);
            if (rsp_valid === 1'b1) begin
                check("sb_nonempty", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("rsp_result", rsp_result, e.res);
                    check("rsp_overflow", rsp_overflow, e.ov);
                    check("rsp_timeout", rsp_timeout, e.to);
                end
                rsp_ready = 1'b1;
                @(posedge clk);
                #1 rsp_ready = 1'b0;
            end
        end
    endtask

    task automatic wait_start();
        int w;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (add_start !== 1'b1 && w < 50);
        check("start_seen", add_start, 1'b1);
    endtask

    task automatic measure_rsp(output int c);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (rsp_valid !== 1'b1 && c < 200);
    endtask

    initial begin
        int c;
        bit seen;
        n_rst     = 1'b0;
        req_valid = 1'b1;
        req_mode  = 1'b0;
        req_op1   = 32'h3F800000;
        req_op2   = 32'h3F800000;
        rsp_ready = 1'b0;
        resp_on   = 1'b1;
        resp_lat  = 1;

        // Reset held with a request on the port: nothing may be pushed.
        repeat (3) @(negedge clk);
        check("rst_count", count, 0);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_add_start", add_start, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        req_valid = 1'b0;
        n_rst     = 1'b1;
        @(negedge clk);
        check("post_rst_count", count, 0);

        // 2.5 + 3.5 with issue and response latency checks.
        push_req(1'b0, 32'h40200000, 32'h40600000, '{32'h40C00000, 1'b0, 1'b0});
        @(negedge clk);
        check("t1_start_early", add_start, 1'b0);
        check("t1_count", count, 1);
        @(negedge clk);
        check("t1_start", add_start, 1'b1);
        check("t1_op1", op1, 32'h40200000);
        check("t1_op2", op2, 32'h40600000);
        check("t1_mode", mode, 1'b0);
        @(negedge clk);
        check("t1_start_pulse", add_start, 1'b0);
        check("t1_rsp_early", rsp_valid, 1'b0);
        @(negedge clk);
        check("t1_rsp_lat", rsp_valid, 1'b1);
        collect(1);

        // 10 + -5 then 10 - 5, plus an overflowing sum.
        resp_lat = 3;
        push_req(1'b0, 32'h41200000, 32'hC0A00000, '{32'h40A00000, 1'b0, 1'b0});
        push_req(1'b1, 32'h41200000, 32'h40A00000, '{32'h40A00000, 1'b0, 1'b0});
        collect(2);
        push_req(1'b0, 32'h7F000000, 32'h7F000000, '{32'h7F800000, 1'b1, 1'b0});
        collect(1);

        // Fill: one response held, four queued, a further request must wait for a pop.
        resp_lat = 2;
        push_rand(1'b0);
        measure_rsp(c);
        check("fill_first_held", rsp_valid, 1'b1);
        for (int i = 0; i < 4; i++) push_rand(1'b0);
        @(negedge clk);
        check("fill_count", count, 4);
        check("fill_req_ready", req_ready, 1'b0);
        check("fill_busy", busy, 1'b1);
        fork
            push_rand(1'b0);
            begin
                repeat (3) @(negedge clk);
                check("fill_fifth_held", count, 4);
                check("fill_sb_size", sb.size(), 5);
                collect(6);
            end
        join

        // Responder silent: timeout after TIMEOUT cycles in WAIT.
        resp_on = 1'b0;
        push_rand(1'b1);
        wait_start();
        measure_rsp(c);
        check("to_latency", c, TIMEOUT + 1);
        collect(1);
        resp_on = 1'b1;

        // Done arrives after the timeout: the abandoned response must stay unchanged.
        resp_lat = 70;
        push_rand(1'b1);
        wait_start();
        measure_rsp(c);
        check("late_latency", c, TIMEOUT + 1);
        repeat (10) @(negedge clk);
        check("late_hold_valid", rsp_valid, 1'b1);
        check("late_hold_result", rsp_result, 32'd0);
        check("late_hold_timeout", rsp_timeout, 1'b1);
        collect(1);
        repeat (5) @(negedge clk);
        check("late_no_extra", rsp_valid, 1'b0);
        check("late_idle", busy, 1'b0);

        // Reset during WAIT: outputs clear at once, the later done is ignored.
        resp_lat = 10;
        push_rand(1'b0);
        wait_start();
        repeat (3) @(negedge clk);
        check("wrst_busy_before", busy, 1'b1);
        #2 n_rst = 1'b0;
        #1;
        check("wrst_busy", busy, 1'b0);
        check("wrst_op1", op1, 32'd0);
        check("wrst_count", count, 0);
        check("wrst_rsp_valid", rsp_valid, 1'b0);
        sb.delete();
        @(negedge clk);
        n_rst = 1'b1;
        seen  = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) seen = 1'b1;
        end
        check("wrst_no_rsp", seen, 1'b0);

        // Random bursts with random responder latency.
        resp_lat = 0;
        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(3, 1);
            for (int j = 0; j < n; j++) push_rand(1'b0);
            collect(n);
        end

        check("start_count", start_cnt, n_pushed);
        check("no_double_start", dbl_start, 1'b0);
        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
